lane_dispatcher: RTL and testbench

Sequencer that feeds the 4-lane vector execution unit (`lanes`) from a full-width vector operation and collects its results. It accepts one vector command (operands A/B of VLEN 32-bit elements plus a 2-bit func), slices it into groups of 4 elements, and drives each group onto the lane operand ports. For each group it holds the operands stable for the func-dependent lane latency, captures `result0..3`, and reports completion once all groups are written back. It sits between the vector register file/decoder and `lanes`, as the issuing end of the lane interface.

---
 rtl/lane_pkg.sv | 35 +++
 rtl/lane_dispatcher_if.sv | 15 +
 rtl/lane_wait_counter.sv | 31 +++
 rtl/lane_dispatcher.sv | 157 +++++++++++++++
 tb/tb_lane_dispatcher.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_pkg.sv
// Shared types and helpers for the lane dispatcher and its wait counter.
package lane_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    FADD = 2'b01,
    MUL  = 2'b10,
    FMUL = 2'b11
  } lane_func_t;

  localparam int unsigned NLANES = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } disp_state_t;

  // Lane latency for a given operation, in cycles.
  function automatic logic [CNT_W-1:0] lat_of(input lane_func_t  func,
                                              input int unsigned lat_add,
                                              input int unsigned lat_fadd,
                                              input int unsigned lat_mul,
                                              input int unsigned lat_fmul);
    unique case (func)
      ADD:     return CNT_W'(lat_add);
      FADD:    return CNT_W'(lat_fadd);
      MUL:     return CNT_W'(lat_mul);
      default: return CNT_W'(lat_fmul);
    endcase
  endfunction

endpackage

// File: rtl/lane_dispatcher_if.sv
// Command/result side of the dispatcher: vector command in, result vector out.
interface lane_dispatcher_if #(
  parameter int unsigned VLEN = 16
);
  logic                 start;
  logic [1:0]           func;
  logic [VLEN*32-1:0]   vec_a;
  logic [VLEN*32-1:0]   vec_b;
  logic                 busy;
  logic                 done;
  logic [VLEN*32-1:0]   vec_res;

  modport master (output start, func, vec_a, vec_b, input busy, done, vec_res);
  modport slave  (input start, func, vec_a, vec_b, output busy, done, vec_res);
endinterface

// File: rtl/lane_wait_counter.sv
// Loadable down-counter; last flags the final cycle of a lane operation.
module lane_wait_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == W'(1));
endmodule

// File: rtl/lane_dispatcher.sv
// Slices a vector command into 4-element groups, issues each to the lanes,
// holds operands for the lane latency and packs the captured results.
module lane_dispatcher
  import lane_pkg::*;
#(
  parameter int unsigned VLEN     = 16,
  parameter int unsigned LAT_ADD  = 1,
  parameter int unsigned LAT_FADD = 15,
  parameter int unsigned LAT_MUL  = 1,
  parameter int unsigned LAT_FMUL = 10
) (
  input  logic               clk,
  input  logic               rst,
  lane_dispatcher_if.slave   cmd,
  output logic [1:0]         lane_func,
  output logic [31:0]        dataA0,
  output logic [31:0]        dataA1,
  output logic [31:0]        dataA2,
  output logic [31:0]        dataA3,
  output logic [31:0]        dataB0,
  output logic [31:0]        dataB1,
  output logic [31:0]        dataB2,
  output logic [31:0]        dataB3,
  input  logic [31:0]        result0,
  input  logic [31:0]        result1,
  input  logic [31:0]        result2,
  input  logic [31:0]        result3
);
  localparam int unsigned NGRP = VLEN / NLANES;
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  disp_state_t                   state_q, state_d;
  logic [GW-1:0]                 g_q, g_d;
  lane_func_t                    func_q, func_d;
  logic [VLEN*32-1:0]            a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]                    lfunc_q, lfunc_d;
  logic [NLANES-1:0][31:0]       opa_q, opa_d, opb_q, opb_d;
  logic [VLEN*32-1:0]            src_a, src_b;
  logic [NLANES-1:0][31:0]       res_in;
  logic                          issue_next, cnt_load, cnt_dec, cnt_last;

  assign res_in = {result3, result2, result1, result0};

  lane_wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (lat_of(func_q, LAT_ADD, LAT_FADD, LAT_MUL, LAT_FMUL)),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // FSM next state, command latching, result capture and operand selection.
  // Operand registers load on the edge that enters ISSUE so they are already
  // on the lane ports during the ISSUE cycle; for group 0 that edge is the
  // accepting one, so the operands come straight from the command inputs.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    func_d     = func_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    lfunc_d    = lfunc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    src_a      = a_q;
    src_b      = b_q;
    issue_next = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd.start) begin
          func_d     = lane_func_t'(cmd.func);
          lfunc_d    = cmd.func;
          a_d        = cmd.vec_a;
          b_d        = cmd.vec_b;
          src_a      = cmd.vec_a;
          src_b      = cmd.vec_b;
          g_d        = '0;
          issue_next = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          for (int unsigned k = 0; k < NLANES; k++) begin
            res_d[(32'(g_q) * NLANES + k) * 32 +: 32] = res_in[k];
          end
          if (g_q == GW'(NGRP - 1)) begin
            state_d = DONE;
          end else begin
            g_d        = g_q + 1'b1;
            issue_next = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (issue_next) begin
      for (int unsigned k = 0; k < NLANES; k++) begin
        opa_d[k] = src_a[(32'(g_d) * NLANES + k) * 32 +: 32];
        opb_d[k] = src_b[(32'(g_d) * NLANES + k) * 32 +: 32];
      end
    end
  end

  // State, latched command, results and lane drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      func_q  <= ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      lfunc_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      lfunc_q <= lfunc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign cmd.busy    = (state_q != IDLE);
  assign cmd.done    = (state_q == DONE);
  assign cmd.vec_res = res_q;
  assign lane_func   = lfunc_q;
  assign dataA0      = opa_q[0];
  assign dataA1      = opa_q[1];
  assign dataA2      = opa_q[2];
  assign dataA3      = opa_q[3];
  assign dataB0      = opb_q[0];
  assign dataB1      = opb_q[1];
  assign dataB2      = opb_q[2];
  assign dataB3      = opb_q[3];
endmodule

// File: tb/tb_lane_dispatcher.sv
// Bench for lane_dispatcher with a latency-aware lane model and a result scoreboard.
module tb_lane_dispatcher;
  localparam int unsigned VLEN     = 8;
  localparam int unsigned NG       = VLEN / 4;
  localparam int unsigned W        = VLEN * 32;
  localparam int unsigned LAT_ADD  = 1;
  localparam int unsigned LAT_FADD = 15;
  localparam int unsigned LAT_MUL  = 1;
  localparam int unsigned LAT_FMUL = 10;

  typedef logic [W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lane_dispatcher_if #(.VLEN(VLEN)) cmd ();

  logic [1:0]  lane_func;
  logic [31:0] dataA0, dataA1, dataA2, dataA3;
  logic [31:0] dataB0, dataB1, dataB2, dataB3;
  logic [31:0] result0, result1, result2, result3;

  lane_dispatcher #(
    .VLEN(VLEN), .LAT_ADD(LAT_ADD), .LAT_FADD(LAT_FADD),
    .LAT_MUL(LAT_MUL), .LAT_FMUL(LAT_FMUL)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .lane_func(lane_func),
    .dataA0(dataA0), .dataA1(dataA1), .dataA2(dataA2), .dataA3(dataA3),
    .dataB0(dataB0), .dataB1(dataB1), .dataB2(dataB2), .dataB3(dataB3),
    .result0(result0), .result1(result1), .result2(result2), .result3(result3)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];

  function automatic int lat(input logic [1:0] f);
    case (f)
      2'b00:   return LAT_ADD;
      2'b01:   return LAT_FADD;
      2'b10:   return LAT_MUL;
      default: return LAT_FMUL;
    endcase
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [31:0] f;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    f = {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    if (d[28] && ((|d[27:0]) || f[0])) f = f + 32'd1;
    return f;
  endfunction

  function automatic logic [31:0] lane_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      2'b00:   return a + b;
      2'b01:   return r2f(f2r(a) + f2r(b));
      2'b10:   return a * b;
      default: return r2f(f2r(a) * f2r(b));
    endcase
  endfunction

  function automatic vec_t exp_vec(input logic [1:0] f, input vec_t a, input vec_t b);
    vec_t r;
    r = '0;
    for (int i = 0; i < VLEN; i++) r[i*32 +: 32] = lane_op(f, a[i*32 +: 32], b[i*32 +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] e0, input logic [31:0] e1,
                                         input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VLEN; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Lane model: a result is valid only once the inputs have been held for LAT cycles.
  logic [257:0] cur_in;
  logic [257:0] prev_in = '0;
  int           hold = 0;
  logic         lane_ok;
  assign cur_in = {lane_func, dataA0, dataA1, dataA2, dataA3, dataB0, dataB1, dataB2, dataB3};

  always @(posedge clk) begin
    hold    <= (cur_in != prev_in) ? 1 : hold + 1;
    prev_in <= cur_in;
  end

  always_comb begin
    lane_ok = (cur_in == prev_in) && (hold >= lat(lane_func));
    result0 = lane_ok ? lane_op(lane_func, dataA0, dataB0) : 32'hDEADBEEF;
    result1 = lane_ok ? lane_op(lane_func, dataA1, dataB1) : 32'hDEADBEEF;
    result2 = lane_ok ? lane_op(lane_func, dataA2, dataB2) : 32'hDEADBEEF;
    result3 = lane_ok ? lane_op(lane_func, dataA3, dataB3) : 32'hDEADBEEF;
  end

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one command; returns just after the accepting edge with inputs scrambled.
  task automatic issue_cmd(input logic [1:0] f, input vec_t a, input vec_t b, input bit push);
    @(negedge clk);
    cmd.start = 1'b1;
    cmd.func  = f;
    cmd.vec_a = a;
    cmd.vec_b = b;
    if (push) exp_q.push_back(exp_vec(f, a, b));
    @(posedge clk);
    #1;
    cmd.start = 1'b0;
    cmd.func  = ~f;
    cmd.vec_a = rand_vec();
    cmd.vec_b = rand_vec();
  endtask

  // Wait for done (bounded), pop the scoreboard and compare vec_res.
  task automatic wait_done(input string name, input int poke_at, output int latency, output int bcnt);
    bit got;
    got = 1'b0;
    latency = 0;
    bcnt = 0;
    while (latency < 2000) begin
      @(negedge clk);
      if (latency == poke_at)     cmd.start = 1'b1;
      if (latency == poke_at + 2) cmd.start = 1'b0;
      if (cmd.busy) bcnt++;
      if (cmd.done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      latency++;
    end
    cmd.start = 1'b0;
    if (!got) begin
      chk({name, "_done_timeout"}, 0, 1);
    end else if (exp_q.size() == 0) begin
      chk({name, "_unexpected_done"}, 1, 0);
    end else begin
      chk({name, "_vec_res"}, cmd.vec_res, exp_q.pop_front());
    end
  endtask

  typedef struct {
    logic [1:0]   func;
    vec_t         a;
    vec_t         b;
    int           exp_lat;
    bit           has_g0;
    logic [127:0] g0_exp;
  } vec_rec_t;

  vec_rec_t tbl[6];

  initial begin
    int          latency, bcnt, cnt;
    logic [257:0] snap;
    vec_t        a, b;

    cmd.start = 1'b0;
    cmd.func  = '0;
    cmd.vec_a = '0;
    cmd.vec_b = '0;

    tbl[0] = '{2'b00,
               {pack4(100, 200, 32'hFFFFFFFF, 5), pack4(32, 333, 32, 74)},
               {pack4(1, 2, 3, 32'h80000000), pack4(63, 12, 41, 12)},
               2 * (1 + LAT_ADD), 1'b1, pack4(95, 345, 73, 86)};
    tbl[1] = '{2'b01,
               {128'd0, pack4(32'h41A9999A, 0, 0, 0)},
               {128'd0, pack4(32'h41BB3333, 0, 0, 0)},
               2 * (1 + LAT_FADD), 1'b1, pack4(32'h42326666, 0, 0, 0)};
    tbl[2] = '{2'b10,
               {pack4(3, 4, 32'h10000, 32'hFFFF), pack4(32, 333, 32, 74)},
               {pack4(5, 6, 32'h10000, 32'hFFFF), pack4(63, 12, 41, 12)},
               2 * (1 + LAT_MUL), 1'b1, pack4(2016, 3996, 1312, 888)};
    tbl[3] = '{2'b11,
               {pack4(32'h40000000, 32'h3F800000, 0, 32'hC0400000), pack4(32'h41A9999A, 0, 0, 0)},
               {pack4(32'h40400000, 32'h3F000000, 0, 32'h40800000), pack4(32'h41BB3333, 0, 0, 0)},
               2 * (1 + LAT_FMUL), 1'b1, {96'd0, 32'h43F80A3E}};
    tbl[4] = '{2'b00, rand_vec(), rand_vec(), 2 * (1 + LAT_ADD), 1'b0, 128'd0};
    tbl[5] = '{2'b10, rand_vec(), rand_vec(), 2 * (1 + LAT_MUL), 1'b0, 128'd0};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", vec_t'(cmd.busy), 0);
    chk("rst_done", vec_t'(cmd.done), 0);
    chk("rst_vec_res", cmd.vec_res, 0);
    chk("rst_lane_func", vec_t'(lane_func), 0);
    chk("rst_operands", vec_t'(cur_in), 0);

    // Table-driven commands, each issued back-to-back after the previous done.
    for (int i = 0; i < 6; i++) begin
      issue_cmd(tbl[i].func, tbl[i].a, tbl[i].b, 1'b1);
      if (tbl[i].func == 2'b01) begin
        // Group 0 operands and func must stay put through ISSUE and all of WAIT.
        @(negedge clk);
        snap = cur_in;
        chk("fadd_lane_func", vec_t'(lane_func), 1);
        chk("fadd_dataA0", vec_t'(dataA0), 32'h41A9999A);
        cnt = 0;
        for (int k = 0; k < LAT_FADD; k++) begin
          @(negedge clk);
          if (cur_in != snap) cnt++;
        end
        chk("fadd_operand_hold", vec_t'(cnt), 0);
        wait_done("fadd", -1, latency, bcnt);
        latency += 1 + LAT_FADD;
        bcnt    += 1 + LAT_FADD;
      end else begin
        wait_done($sformatf("tbl%0d", i), -1, latency, bcnt);
      end
      chk($sformatf("tbl%0d_latency", i), vec_t'(latency), vec_t'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_busy_cycles", i), vec_t'(bcnt), vec_t'(tbl[i].exp_lat + 1));
      if (tbl[i].has_g0) chk($sformatf("tbl%0d_group0", i), vec_t'(cmd.vec_res[127:0]), vec_t'(tbl[i].g0_exp));
    end

    // Start pulsed mid-operation is ignored: same latency, single done.
    issue_cmd(2'b10, tbl[2].a, tbl[2].b, 1'b1);
    wait_done("mul_poke", 1, latency, bcnt);
    chk("mul_poke_latency", vec_t'(latency), 2 * (1 + LAT_MUL));
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd.done) cnt++;
    end
    chk("mul_poke_extra_done", vec_t'(cnt), 0);

    // Reset in the middle of a float-multiply WAIT aborts without done.
    issue_cmd(2'b11, tbl[3].a, tbl[3].b, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", vec_t'(cmd.busy), 0);
    chk("abort_vec_res", cmd.vec_res, 0);
    chk("abort_lane_func", vec_t'(lane_func), 0);
    chk("abort_operands", vec_t'(cur_in), 0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cmd.done) cnt++;
    end
    chk("abort_no_done", vec_t'(cnt), 0);
    issue_cmd(2'b11, tbl[3].a, tbl[3].b, 1'b1);
    wait_done("fmul_after_abort", -1, latency, bcnt);
    chk("fmul_after_abort_latency", vec_t'(latency), 2 * (1 + LAT_FMUL));

    // Back-to-back: second start on the first IDLE cycle after done overwrites results.
    a = rand_vec();
    b = rand_vec();
    issue_cmd(2'b00, a, b, 1'b1);
    wait_done("b2b_first", -1, latency, bcnt);
    a = rand_vec();
    b = rand_vec();
    issue_cmd(2'b10, a, b, 1'b1);
    wait_done("b2b_second", -1, latency, bcnt);
    chk("b2b_second_latency", vec_t'(latency), 2 * (1 + LAT_MUL));
    @(negedge clk);
    chk("idle_after_done", vec_t'(cmd.busy), 0);
    chk("vec_res_held", cmd.vec_res, exp_vec(2'b10, a, b));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
